// File: rtl/multicycle_control.sv
// Multicycle datapath control FSM: Moore-decoded control word per state,
// memory handshake stalls, sticky illegal-opcode flag.
module multicycle_control #(
    parameter logic HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EX   = 4'd10,
        ADDI_WB   = 4'd11,
        HALT      = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;

    logic       pc_write_c, pc_write_cond_c, i_or_d_c, mem_read_c;
    logic       mem_write_c, ir_write_c, mem_to_reg_c, reg_dst_c;
    logic       reg_write_c, alu_src_a_c;
    logic [1:0] alu_src_b_c, alu_op_c, pc_source_c;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        illegal_d       = illegal_q;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        i_or_d_c        = 1'b0;
        mem_read_c      = 1'b0;
        mem_write_c     = 1'b0;
        ir_write_c      = 1'b0;
        mem_to_reg_c    = 1'b0;
        reg_dst_c       = 1'b0;
        reg_write_c     = 1'b0;
        alu_src_a_c     = 1'b0;
        alu_src_b_c     = 2'b00;
        alu_op_c        = 2'b00;
        pc_source_c     = 2'b00;
        unique case (state_q)
            FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b01;
                ir_write_c  = mem_ready;
                pc_write_c  = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                alu_src_b_c = 2'b11;
                unique case (opcode)
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDI_EX;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = HALT_ON_ILLEGAL ? HALT : FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                if (opcode == OP_LW)      state_d = MEM_READ;
                else if (opcode == OP_SW) state_d = MEM_WRITE;
                else                      state_d = FETCH;
            end
            MEM_READ: begin
                mem_read_c = 1'b1;
                i_or_d_c   = 1'b1;
                if (mem_ready) state_d = MEM_WB;
            end
            MEM_WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
                state_d      = FETCH;
            end
            MEM_WRITE: begin
                mem_write_c = 1'b1;
                i_or_d_c    = 1'b1;
                if (mem_ready) state_d = FETCH;
            end
            EXECUTE: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = 2'b10;
                state_d     = R_WB;
            end
            R_WB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
                state_d     = FETCH;
            end
            BRANCH: begin
                alu_src_a_c     = 1'b1;
                alu_op_c        = 2'b01;
                pc_write_cond_c = 1'b1;
                pc_source_c     = 2'b01;
                state_d         = FETCH;
            end
            JUMP: begin
                pc_write_c  = 1'b1;
                pc_source_c = 2'b10;
                state_d     = FETCH;
            end
            ADDI_EX: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                state_d     = ADDI_WB;
            end
            ADDI_WB: begin
                reg_write_c = 1'b1;
                state_d     = FETCH;
            end
            HALT: state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Reset gates the decoded word so no access is issued while reset_n is low
    assign pc_write      = reset_n & pc_write_c;
    assign pc_write_cond = reset_n & pc_write_cond_c;
    assign i_or_d        = reset_n & i_or_d_c;
    assign mem_read      = reset_n & mem_read_c;
    assign mem_write     = reset_n & mem_write_c;
    assign ir_write      = reset_n & ir_write_c;
    assign mem_to_reg    = reset_n & mem_to_reg_c;
    assign reg_dst       = reset_n & reg_dst_c;
    assign reg_write     = reset_n & reg_write_c;
    assign alu_src_a     = reset_n & alu_src_a_c;
    assign alu_src_b     = reset_n ? alu_src_b_c : 2'b00;
    assign alu_op        = reset_n ? alu_op_c : 2'b00;
    assign pc_source     = reset_n ? pc_source_c : 2'b00;
    assign state         = state_q;
    assign illegal       = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed instruction sequences,
// both HALT_ON_ILLEGAL settings, asynchronous reset mid-access.
module tb_multicycle_control;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       dut_sel = 1'b1;

    logic       pcw1, pcwc1, iod1, mr1, mw1, irw1, m2r1, rd1, rw1, sa1;
    logic [1:0] sb1, op1, ps1;
    logic [3:0] st1;
    logic       ill1;
    logic       pcw0, pcwc0, iod0, mr0, mw0, irw0, m2r0, rd0, rw0, sa0;
    logic [1:0] sb0, op0, ps0;
    logic [3:0] st0;
    logic       ill0;

    // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
    logic [15:0] ctrl1, ctrl0;
    assign ctrl1 = {pcw1, pcwc1, iod1, mr1, mw1, irw1, m2r1, rd1, rw1, sa1, sb1, op1, ps1};
    assign ctrl0 = {pcw0, pcwc0, iod0, mr0, mw0, irw0, m2r0, rd0, rw0, sa0, sb0, op0, ps0};

    localparam logic [15:0] C_FETCH = 16'h9410;
    localparam logic [15:0] C_FSTL  = 16'h1010;
    localparam logic [15:0] C_DEC   = 16'h0030;
    localparam logic [15:0] C_MADDR = 16'h0060;
    localparam logic [15:0] C_MRD   = 16'h3000;
    localparam logic [15:0] C_MWB   = 16'h0280;
    localparam logic [15:0] C_MWR   = 16'h2800;
    localparam logic [15:0] C_EXE   = 16'h0048;
    localparam logic [15:0] C_RWB   = 16'h0180;
    localparam logic [15:0] C_BR    = 16'h4045;
    localparam logic [15:0] C_JMP   = 16'h8002;
    localparam logic [15:0] C_AEX   = 16'h0060;
    localparam logic [15:0] C_AWB   = 16'h0080;
    localparam logic [15:0] C_ZERO  = 16'h0000;

    multicycle_control #(.HALT_ON_ILLEGAL(1'b1)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pcw1), .pc_write_cond(pcwc1), .i_or_d(iod1), .mem_read(mr1),
        .mem_write(mw1), .ir_write(irw1), .mem_to_reg(m2r1), .reg_dst(rd1),
        .reg_write(rw1), .alu_src_a(sa1), .alu_src_b(sb1), .alu_op(op1),
        .pc_source(ps1), .state(st1), .illegal(ill1)
    );

    multicycle_control #(.HALT_ON_ILLEGAL(1'b0)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pcw0), .pc_write_cond(pcwc0), .i_or_d(iod0), .mem_read(mr0),
        .mem_write(mw0), .ir_write(irw0), .mem_to_reg(m2r0), .reg_dst(rd0),
        .reg_write(rw0), .alu_src_a(sa0), .alu_src_b(sb0), .alu_op(op0),
        .pc_source(ps0), .state(st0), .illegal(ill0)
    );

    always #5 clock = ~clock;

    logic [21:0] q_exp[$];
    string       q_name[$];
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic push(input logic [3:0] st, input logic [15:0] c,
                        input logic il, input string nm);
        q_exp.push_back({dut_sel, st, c, il});
        q_name.push_back(nm);
    endtask

    task automatic step(input logic mr, input logic [5:0] op,
                        input logic [3:0] st, input logic [15:0] c,
                        input logic il, input string nm);
        @(posedge clock);
        #1;
        mem_ready = mr;
        opcode    = op;
        push(st, c, il, nm);
    endtask

    task automatic do_reset(input string nm);
        @(posedge clock);
        #1;
        reset_n   = 1'b0;
        mem_ready = 1'b0;
        push(4'd0, C_ZERO, 1'b0, nm);
        @(posedge clock);
        #1;
        push(4'd0, C_ZERO, 1'b0, nm);
        @(negedge clock);
        #2;
        reset_n = 1'b1;
    endtask

    // Monitor: pops one expectation per sampled cycle
    always @(negedge clock) begin
        if (q_exp.size() > 0) begin
            logic [21:0] e;
            logic [20:0] act;
            string       nm;
            e  = q_exp.pop_front();
            nm = q_name.pop_front();
            act = e[21] ? {st1, ctrl1, ill1} : {st0, ctrl0, ill0};
            n_tests++;
            if (act !== e[20:0]) begin
                n_fail++;
                $display("FAIL %s: got state=%0d ctrl=%h illegal=%b, want state=%0d ctrl=%h illegal=%b",
                         nm, act[20:17], act[16:1], act[0], e[20:17], e[16:1], e[0]);
            end
        end
    end

    initial begin
        dut_sel = 1'b1;
        do_reset("reset");

        step(1, 6'h00, 4'd0, C_FETCH, 0, "r_fetch");
        step(1, 6'h00, 4'd1, C_DEC,   0, "r_decode");
        step(1, 6'h00, 4'd6, C_EXE,   0, "r_execute");
        step(1, 6'h00, 4'd7, C_RWB,   0, "r_wb");

        step(0, 6'h23, 4'd0, C_FSTL,  0, "lw_fetch_stall");
        step(1, 6'h23, 4'd0, C_FETCH, 0, "lw_fetch");
        step(0, 6'h23, 4'd1, C_DEC,   0, "lw_decode_ready_ignored");
        step(1, 6'h23, 4'd2, C_MADDR, 0, "lw_mem_addr");
        step(0, 6'h00, 4'd3, C_MRD,   0, "lw_mem_read_w1");
        step(0, 6'h23, 4'd3, C_MRD,   0, "lw_mem_read_w2");
        step(0, 6'h23, 4'd3, C_MRD,   0, "lw_mem_read_w3");
        step(1, 6'h23, 4'd3, C_MRD,   0, "lw_mem_read_done");
        step(0, 6'h23, 4'd4, C_MWB,   0, "lw_mem_wb");

        step(1, 6'h2b, 4'd0, C_FETCH, 0, "sw_fetch");
        step(1, 6'h2b, 4'd1, C_DEC,   0, "sw_decode");
        step(1, 6'h2b, 4'd2, C_MADDR, 0, "sw_mem_addr");
        step(1, 6'h2b, 4'd5, C_MWR,   0, "sw_mem_write");

        step(1, 6'h04, 4'd0, C_FETCH, 0, "beq_fetch");
        step(1, 6'h04, 4'd1, C_DEC,   0, "beq_decode");
        step(1, 6'h04, 4'd8, C_BR,    0, "beq_branch");

        step(1, 6'h02, 4'd0, C_FETCH, 0, "j_fetch");
        step(1, 6'h02, 4'd1, C_DEC,   0, "j_decode");
        step(1, 6'h02, 4'd9, C_JMP,   0, "j_jump");

        step(1, 6'h08, 4'd0,  C_FETCH, 0, "addi_fetch");
        step(1, 6'h08, 4'd1,  C_DEC,   0, "addi_decode");
        step(1, 6'h08, 4'd10, C_AEX,   0, "addi_ex");
        step(0, 6'h08, 4'd11, C_AWB,   0, "addi_wb");

        step(1, 6'h3f, 4'd0,  C_FETCH, 0, "ill_fetch");
        step(1, 6'h3f, 4'd1,  C_DEC,   0, "ill_decode");
        step(1, 6'h00, 4'd12, C_ZERO,  1, "ill_halt1");
        step(0, 6'h23, 4'd12, C_ZERO,  1, "ill_halt2");
        step(1, 6'h3f, 4'd12, C_ZERO,  1, "ill_halt3");
        do_reset("reset_clears_illegal");

        step(1, 6'h2b, 4'd0, C_FETCH, 0, "rst_sw_fetch");
        step(1, 6'h2b, 4'd1, C_DEC,   0, "rst_sw_decode");
        step(1, 6'h2b, 4'd2, C_MADDR, 0, "rst_sw_mem_addr");
        step(0, 6'h2b, 4'd5, C_MWR,   0, "rst_sw_write_stall");
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        push(4'd0, C_ZERO, 1'b0, "async_reset_mid_write");
        @(negedge clock);
        #2;
        reset_n = 1'b1;
        step(1, 6'h00, 4'd0, C_FETCH, 0, "resume_fetch");
        step(1, 6'h00, 4'd1, C_DEC,   0, "resume_decode");

        dut_sel = 1'b0;
        do_reset("nohalt_reset");
        step(1, 6'h3f, 4'd0, C_FETCH, 0, "nohalt_fetch");
        step(1, 6'h3f, 4'd1, C_DEC,   0, "nohalt_decode");
        step(1, 6'h00, 4'd0, C_FETCH, 1, "nohalt_back_to_fetch");
        step(1, 6'h00, 4'd1, C_DEC,   1, "nohalt_decode2");
        step(1, 6'h00, 4'd6, C_EXE,   1, "nohalt_execute_sticky");

        @(posedge clock);
        @(negedge clock);
        #1;
        n_tests++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", q_exp.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
